// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch controller: FSM state values and KEY bit positions.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int KEY_START = 0;
  localparam int KEY_CLEAR = 1;

endpackage

// File: rtl/key_debounce.sv
// One active-low key: 2-flop synchroniser, stability-count debouncer and a one-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Only the 1->0 acceptance is an event; releases flip silently.
        stable <= sync2;
        cnt    <= '0;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller: debounced keys drive an Idle/Run/Pause FSM and a gated tick prescaler.
// Define STOPWATCH_AUTOSTOP_EN to pause automatically when the counter sits at 59:59.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] KEY,
  input  logic       max_reached,
  output logic       tick,
  output logic       clr,
  output logic       running,
  output logic [1:0] state
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic          start_evt;
  logic          clear_evt;
  state_t        cur_state;
  state_t        nxt_state;
  logic [PW-1:0] presc;
  logic          terminal;
  logic          autostop;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key   (KEY[KEY_START]),
    .press (start_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_clear (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .key   (KEY[KEY_CLEAR]),
    .press (clear_evt)
  );

  assign terminal = (presc == PRESC_LAST);

`ifdef STOPWATCH_AUTOSTOP_EN
  assign autostop = terminal & max_reached;
`else
  logic unused_max_reached;
  assign unused_max_reached = max_reached;
  assign autostop = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) cur_state <= ST_IDLE;
    else          cur_state <= nxt_state;
  end

  // Clear outranks start; autostop only applies when no key event is pending.
  always_comb begin
    nxt_state = cur_state;
    if (clear_evt) begin
      nxt_state = ST_IDLE;
    end else if (start_evt) begin
      case (cur_state)
        ST_IDLE, ST_PAUSE: nxt_state = ST_RUN;
        ST_RUN:            nxt_state = ST_PAUSE;
        default:           nxt_state = ST_IDLE;
      endcase
    end else if (cur_state == ST_RUN && autostop) begin
      nxt_state = ST_PAUSE;
    end
  end

  always_comb begin
    running = (cur_state == ST_RUN);
    state   = cur_state;
  end

  // Prescaler advances only while staying in RUN, so a pause freezes the fractional second.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      presc <= '0;
      tick  <= 1'b0;
      clr   <= 1'b0;
    end else begin
      tick <= 1'b0;
      clr  <= clear_evt;
      if (nxt_state == ST_IDLE) begin
        presc <= '0;
      end else if (cur_state == ST_RUN && nxt_state == ST_RUN) begin
        if (terminal) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end else if (cur_state == ST_RUN && !start_evt && autostop) begin
        presc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: cycle model checked every cycle plus directed literal expectations.
module tb_stopwatch_ctrl;
  localparam int N  = 100;
  localparam int DB = 4;
`ifdef STOPWATCH_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key = 2'b11;
  logic       max_reached = 1'b0;
  logic       tick;
  logic       clr;
  logic       running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.CLK_HZ(N), .TICK_HZ(1), .DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .KEY         (key),
    .max_reached (max_reached),
    .tick        (tick),
    .clr         (clr),
    .running     (running),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a key press is accepted once the raw samples taken 2..DB+1 edges ago all
  // disagree with the accepted level; the FSM reacts to that press one edge later.
  int m_state;
  int m_presc;
  bit m_tick;
  bit m_clr;
  bit m_evt [2];
  bit m_acc [2];
  bit hist  [2][DB+1];
  bit model_valid = 1'b0;
  bit se, ce, diff;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_presc = 0; m_tick = 0; m_clr = 0;
      for (int k = 0; k < 2; k++) begin
        m_evt[k] = 0; m_acc[k] = 1;
        for (int j = 0; j <= DB; j++) hist[k][j] = 1;
      end
      model_valid = 1'b1;
    end else begin
      se = m_evt[0];
      ce = m_evt[1];
      m_tick = 0;
      m_clr  = 0;
      if (ce) begin
        m_state = 0; m_presc = 0; m_clr = 1;
      end else if (se) begin
        if (m_state == 0) begin m_state = 1; m_presc = 0; end
        else if (m_state == 1) m_state = 2;
        else m_state = 1;
      end else if (m_state == 1) begin
        if (m_presc == N - 1) begin
          if (AUTOSTOP && max_reached) begin m_state = 2; m_presc = 0; end
          else begin m_presc = 0; m_tick = 1; end
        end else begin
          m_presc++;
        end
      end
      for (int k = 0; k < 2; k++) begin
        m_evt[k] = 0;
        diff = 1;
        for (int j = 1; j <= DB; j++) if (hist[k][j] == m_acc[k]) diff = 0;
        if (diff) begin
          m_acc[k] = !m_acc[k];
          m_evt[k] = (m_acc[k] == 0);
        end
        for (int j = DB; j >= 1; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = key[k];
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("tick", int'(tick), int'(m_tick));
      check("clr", int'(clr), int'(m_clr));
      check("state", int'(state), m_state);
      check("running", int'(running), int'(m_state == 1));
    end
  end

  // Drive the masked keys low at the current negedge and release them 10 cycles later.
  task press(input logic [1:0] mask);
    key = key & ~mask;
    fork
      begin
        repeat (10) @(negedge clk);
        key = 2'b11;
      end
    join_none
  endtask

  task automatic wait_state(input int want, output int edges);
    bit hit;
    edges = 0; hit = 0;
    while (!hit && edges < 60) begin
      @(posedge clk); #1;
      edges++;
      if (int'(state) == want) hit = 1;
    end
  endtask

  task automatic wait_tick(output int edges);
    bit hit;
    edges = 0; hit = 0;
    while (!hit && edges < 2 * N) begin
      @(posedge clk); #1;
      edges++;
      if (tick) hit = 1;
    end
  endtask

  task automatic wait_presc(input int v);
    int n;
    n = 0;
    while (m_presc != v && n < 3 * N) begin
      @(negedge clk);
      n++;
    end
    check("reach_presc", m_presc, v);
  endtask

  int e, clr_cnt, clr_edge, tick_cnt, bad_cnt;

  initial begin
    // Reset held for two edges.
    repeat (2) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_clr", int'(clr), 0);
    check("rst_running", int'(running), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start: RUN appears on the 7th edge after KEY drops (6 cycles after the first sampling edge).
    press(2'b01);
    wait_state(1, e);
    check("start_latency", e, 7);
    wait_tick(e);
    check("first_tick", e, N);
    wait_tick(e);
    check("tick_period", e, N);

    // Pause lands with the prescaler at 41; resume must tick after the remaining 59 cycles.
    @(negedge clk);
    wait_presc(35);
    press(2'b01);
    wait_state(2, e);
    check("pause_latency", e, 7);
    check("pause_presc", m_presc, 41);
    repeat (480) @(negedge clk);
    press(2'b01);
    wait_state(1, e);
    check("resume_latency", e, 7);
    wait_tick(e);
    check("resume_tick", e, 59);

    // Both keys together while running: clear wins.
    @(negedge clk);
    press(2'b11);
    clr_cnt = 0; clr_edge = 0; tick_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (clr) begin clr_cnt++; clr_edge = i; end
      if (tick) tick_cnt++;
    end
    check("clear_pulses", clr_cnt, 1);
    check("clear_edge", clr_edge, 7);
    check("clear_no_tick", tick_cnt, 0);
    check("clear_state", int'(state), 0);
    check("clear_presc", m_presc, 0);

    // Bouncing start key in IDLE: never stable for DB samples.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      key[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    key = 2'b11;
    bad_cnt = 0; tick_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (state != 2'd0) bad_cnt++;
      if (tick) tick_cnt++;
    end
    check("bounce_state", bad_cnt, 0);
    check("bounce_tick", tick_cnt, 0);

    // max_reached held at the terminal count.
    @(negedge clk);
    press(2'b01);
    wait_state(1, e);
    check("start2_latency", e, 7);
    @(negedge clk);
    max_reached = 1'b1;
    tick_cnt = 0;
    for (int i = 1; i < N; i++) begin
      @(posedge clk); #1;
      if (tick) tick_cnt++;
    end
    check("autostop_early_tick", tick_cnt, 0);
    @(posedge clk); #1;
`ifdef STOPWATCH_AUTOSTOP_EN
    check("autostop_tick", int'(tick), 0);
    check("autostop_state", int'(state), 2);
`else
    check("autostop_tick", int'(tick), 1);
    check("autostop_state", int'(state), 1);
`endif
    @(negedge clk);
    max_reached = 1'b0;
    if (m_state != 1) begin
      press(2'b01);
      wait_state(1, e);
      check("restart_latency", e, 7);
      @(negedge clk);
    end

    // Reset in the middle of a running second.
    wait_presc(70);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_state", int'(state), 0);
    check("midrst_tick", int'(tick), 0);
    check("midrst_clr", int'(clr), 0);
    check("midrst_running", int'(running), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      if (tick) tick_cnt++;
      if (state != 2'd0) bad_cnt++;
    end
    check("postrst_tick", tick_cnt, 0);
    check("postrst_state", bad_cnt, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
